mac_avl_bridge: RTL and testbench

Two-client Avalon-MM bridge that sits directly downstream of the MAC configuration sequencer and drives the TSE MAC control register port. It converts the sequencer-style request interface into Avalon-MM transfers with `waitrequest`. That interface is: hold `read_req`/`write_req` until `busy` is seen low, then drop the request. A second client (runtime statistics poller) shares the same MAC port through round-robin arbitration. A watchdog aborts transfers the MAC never completes, so the config sequence cannot hang.

---
 rtl/mac_avl_pkg.sv | 21 ++
 rtl/mac_avl_rr_arb.sv | 24 ++
 rtl/mac_avl_bridge.sv | 123 ++++++++++++
 tb/tb_mac_avl_bridge.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_avl_pkg.sv
// Shared types and constants for the MAC Avalon-MM bridge.
// Imported by the arbiter and the bridge top.
package mac_avl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int          NUM_CLIENTS    = 2;
    localparam int          ADDR_W         = 8;
    localparam logic [31:0] ABORT_DATA_DEF = 32'hDEADBEEF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              wr;
    } creq_t;

endpackage

// File: rtl/mac_avl_rr_arb.sv
// Two-request round-robin arbiter.
// On a tie the client not granted last wins.
module mac_avl_rr_arb
    import mac_avl_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   last_grant,
    output logic                   grant,
    output logic                   valid
);

    assign valid = |req;

    // pick the requester; ties go to the client that waited
    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req == 2'b11): grant = ~last_grant;
            (req == 2'b10): grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mac_avl_bridge.sv
// Two-client request/busy to Avalon-MM bridge for the TSE MAC port.
// Round-robin shared access with a waitrequest watchdog.
module mac_avl_bridge
    import mac_avl_pkg::*;
#(
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] ABORT_DATA = ABORT_DATA_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [31:0]       c0_writedata,
    input  logic              c0_read_req,
    input  logic              c0_write_req,
    output logic              c0_busy,
    output logic [31:0]       c0_readdata,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [31:0]       c1_writedata,
    input  logic              c1_read_req,
    input  logic              c1_write_req,
    output logic              c1_busy,
    output logic [31:0]       c1_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic [31:0]       avm_writedata,
    output logic              avm_read,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              timeout_err
);

    localparam logic [9:0] TLAST = 10'(TIMEOUT - 1);

    state_t                 state;
    logic                   grant;
    logic                   last_grant;
    logic [9:0]             tcount;
    logic [31:0]            rdata;
    logic [NUM_CLIENTS-1:0] req;
    logic                   arb_grant;
    logic                   arb_valid;
    creq_t                  c0_bundle;
    creq_t                  c1_bundle;
    creq_t                  sel;

    assign req = {c1_read_req | c1_write_req,
                  c0_read_req | c0_write_req};

    // read+write together is served as a write
    assign c0_bundle = '{addr: c0_address, wdata: c0_writedata, wr: c0_write_req};
    assign c1_bundle = '{addr: c1_address, wdata: c1_writedata, wr: c1_write_req};
    assign sel       = arb_grant ? c1_bundle : c0_bundle;

    mac_avl_rr_arb u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign c0_busy     = !(state == RESP && grant == 1'b0);
    assign c1_busy     = !(state == RESP && grant == 1'b1);
    assign c0_readdata = rdata;
    assign c1_readdata = rdata;

    // transfer sequencer: grant, hold the Avalon strobe, report or abort
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            tcount        <= '0;
            rdata         <= '0;
            timeout_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant         <= arb_grant;
                        last_grant    <= arb_grant;
                        avm_address   <= sel.addr;
                        avm_writedata <= sel.wdata;
                        avm_write     <= sel.wr;
                        avm_read      <= !sel.wr;
                        tcount        <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_read) begin
                            rdata <= avm_readdata;
                        end
                        state <= RESP;
                    end else if (tcount == TLAST) begin
                        avm_read    <= 1'b0;
                        avm_write   <= 1'b0;
                        timeout_err <= 1'b1;
                        if (avm_read) begin
                            rdata <= ABORT_DATA;
                        end
                        state <= RESP;
                    end else begin
                        tcount <= tcount + 10'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_avl_bridge.sv
// Self-checking bench for mac_avl_bridge with a register-file MAC model.
// Randomized client traffic checked against latency and data expectations.
module tb_mac_avl_bridge;

    localparam int TMO = 8;

    logic        clock;
    logic        reset;
    logic [7:0]  c0_address;
    logic [31:0] c0_writedata;
    logic        c0_read_req;
    logic        c0_write_req;
    logic        c0_busy;
    logic [31:0] c0_readdata;
    logic [7:0]  c1_address;
    logic [31:0] c1_writedata;
    logic        c1_read_req;
    logic        c1_write_req;
    logic        c1_busy;
    logic [31:0] c1_readdata;
    logic [7:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        timeout_err;

    int vectors;
    int miscompares;

    logic [31:0] mac_mem [256];
    logic [31:0] ref_mem [256];
    int          wait_cfg;
    bit          rand_wait;
    int          cur_wait;
    bit          active;
    int          wcnt;
    int          scnt;
    int          mac_done;
    int          model_last;
    bit          cfg_done;

    mac_avl_bridge #(.TIMEOUT(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .c0_address      (c0_address),
        .c0_writedata    (c0_writedata),
        .c0_read_req     (c0_read_req),
        .c0_write_req    (c0_write_req),
        .c0_busy         (c0_busy),
        .c0_readdata     (c0_readdata),
        .c1_address      (c1_address),
        .c1_writedata    (c1_writedata),
        .c1_read_req     (c1_read_req),
        .c1_write_req    (c1_write_req),
        .c1_busy         (c1_busy),
        .c1_readdata     (c1_readdata),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .timeout_err     (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MAC model: stalls cur_wait cycles per transfer, then answers from its register file
    always @(negedge clock) begin
        if (avm_read || avm_write) begin
            if (!active) begin
                active   = 1'b1;
                cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (wcnt < cur_wait) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                wcnt++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = mac_mem[avm_address];
            end
        end else begin
            active          = 1'b0;
            wcnt            = 0;
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
        end
    end

    // bus monitor: strobe length and accepted writes
    always @(posedge clock) begin
        if (avm_read || avm_write) scnt++;
        else scnt = 0;
        if (!reset && (avm_read || avm_write) && !avm_waitrequest) begin
            mac_done++;
            if (avm_write) mac_mem[avm_address] = avm_writedata;
        end
    end

    task automatic xfer(input int c, input int mode, input logic [7:0] a,
                        input logic [31:0] d, input bit gap,
                        output logic [31:0] rd, output int lat, output int slen,
                        output logic [7:0] sa, output logic [31:0] sd,
                        output logic sr, output logic sw);
        bit done;
        done = 0; lat = 0; slen = 0; rd = '0;
        sa = '0; sd = '0; sr = 1'b0; sw = 1'b0;
        if (gap) begin
            @(posedge clock);
            @(negedge clock);
        end
        if (c == 0) begin
            c0_address = a; c0_writedata = d;
            c0_read_req = (mode != 1); c0_write_req = (mode != 0);
        end else begin
            c1_address = a; c1_writedata = d;
            c1_read_req = (mode != 1); c1_write_req = (mode != 0);
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) begin
                sa = avm_address; sd = avm_writedata;
                sr = avm_read;    sw = avm_write;
            end
            if ((c == 0 && !c0_busy) || (c == 1 && !c1_busy)) begin
                rd   = (c == 0) ? c0_readdata : c1_readdata;
                slen = scnt;
                done = 1;
            end
        end
        if (c == 0) begin
            c0_read_req = 1'b0; c0_write_req = 1'b0;
        end else begin
            c1_read_req = 1'b0; c1_write_req = 1'b0;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL xfer_wait c%0d: busy never low in 200 cycles, required one completion", c);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobe: rd=%b wr=%b required 0 0", avm_read, avm_write);
        end
        vectors++;
        if (avm_address !== 8'h00 || avm_writedata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr: %h %h required 0 0", avm_address, avm_writedata);
        end
        vectors++;
        if (c0_busy !== 1'b1 || c1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: %b %b required 1 1", c0_busy, c1_busy);
        end
        vectors++;
        if (c0_readdata !== 32'h0 || c1_readdata !== 32'h0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: %h %h err=%b required 0 0 0",
                     c0_readdata, c1_readdata, timeout_err);
        end
        @(negedge clock);
        reset = 1'b0;
        model_last = 1;
    endtask

    task automatic test_write();
        logic [31:0] rd, sd;
        logic [7:0]  sa;
        logic        sr, sw;
        int          lat, slen;
        wait_cfg = 0;
        ref_mem[8'h02] = 32'h0000_0043;
        xfer(0, 1, 8'h02, 32'h0000_0043, 1'b1, rd, lat, slen, sa, sd, sr, sw);
        model_last = 0;
        vectors++;
        if (lat !== 2 || slen !== 1) begin
            miscompares++;
            $display("FAIL write_timing: lat=%0d strobe=%0d required 2 1", lat, slen);
        end
        vectors++;
        if (sa !== 8'h02 || sd !== 32'h43 || sw !== 1'b1 || sr !== 1'b0) begin
            miscompares++;
            $display("FAIL write_bus: a=%h d=%h w=%b r=%b required 02 43 1 0", sa, sd, sw, sr);
        end
        vectors++;
        if (c1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_c1_busy: %b required 1", c1_busy);
        end
        vectors++;
        if (mac_mem[8'h02] !== ref_mem[8'h02]) begin
            miscompares++;
            $display("FAIL write_mem: %h required %h", mac_mem[8'h02], ref_mem[8'h02]);
        end
    endtask

    task automatic test_read();
        logic [31:0] rd, sd;
        logic [7:0]  sa;
        logic        sr, sw;
        int          lat, slen;
        wait_cfg = 3;
        mac_mem[8'h1A] = 32'h1234_5678;
        ref_mem[8'h1A] = 32'h1234_5678;
        xfer(1, 0, 8'h1A, 32'h0, 1'b1, rd, lat, slen, sa, sd, sr, sw);
        model_last = 1;
        vectors++;
        if (lat !== 5 || slen !== 4) begin
            miscompares++;
            $display("FAIL read_timing: lat=%0d strobe=%0d required 5 4", lat, slen);
        end
        vectors++;
        if (rd !== 32'h1234_5678 || sa !== 8'h1A || sr !== 1'b1) begin
            miscompares++;
            $display("FAIL read_data: rd=%h a=%h r=%b required 12345678 1a 1", rd, sa, sr);
        end
        vectors++;
        if (c0_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_c0_busy: %b required 1", c0_busy);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (c1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_busy_pulse: %b required 1", c1_busy);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] rda, rdb, d0, d1, sd;
        logic [7:0]  a0, a1, sa;
        logic        sr, sw;
        int          la, lb, sla, slb, m0, m1, w, lw, ll;
        wait_cfg = 0;
        for (int it = 0; it < 5; it++) begin
            if (it >= 2 && $urandom_range(0, 1) == 1) begin
                w = int'($urandom_range(0, 1));
                a0 = 8'($urandom_range(0, 63)) | ((w == 1) ? 8'h40 : 8'h00);
                xfer(w, 0, a0, 32'h0, 1'b1, rda, la, sla, sa, sd, sr, sw);
                model_last = w;
                vectors++;
                if (la !== 2 || rda !== ref_mem[a0]) begin
                    miscompares++;
                    $display("FAIL arb_solo c%0d: lat=%0d rd=%h required 2 %h", w, la, rda, ref_mem[a0]);
                end
            end
            m0 = int'($urandom_range(0, 2)); m1 = int'($urandom_range(0, 2));
            a0 = 8'($urandom_range(0, 63)); a1 = 8'($urandom_range(0, 63)) | 8'h40;
            d0 = $urandom; d1 = $urandom;
            if (m0 != 0) ref_mem[a0] = d0;
            if (m1 != 0) ref_mem[a1] = d1;
            w = (model_last == 1) ? 0 : 1;
            fork
                xfer(0, m0, a0, d0, 1'b1, rda, la, sla, sa, sd, sr, sw);
                xfer(1, m1, a1, d1, 1'b1, rdb, lb, slb, sa, sd, sr, sw);
            join
            model_last = 1 - w;
            lw = (w == 0) ? la : lb;
            ll = (w == 0) ? lb : la;
            vectors++;
            if (lw !== 2 || ll !== 5) begin
                miscompares++;
                $display("FAIL arb_tie it%0d: winner c%0d lat=%0d loser lat=%0d required 2 5", it, w, lw, ll);
            end
            vectors++;
            if ((m0 == 0 && rda !== ref_mem[a0]) || (m1 == 0 && rdb !== ref_mem[a1])) begin
                miscompares++;
                $display("FAIL arb_data it%0d: %h %h required %h %h", it, rda, rdb, ref_mem[a0], ref_mem[a1]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd, sd;
        logic [7:0]  sa;
        logic        sr, sw;
        int          lat, slen, md;
        wait_cfg = 1000;
        md = mac_done;
        xfer(0, 0, 8'h05, 32'h0, 1'b1, rd, lat, slen, sa, sd, sr, sw);
        model_last = 0;
        vectors++;
        if (lat !== TMO + 1 || slen !== TMO || sr !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_timing: lat=%0d strobe=%0d required %0d %0d", lat, slen, TMO + 1, TMO);
        end
        vectors++;
        if (rd !== 32'hDEADBEEF || timeout_err !== 1'b1 || mac_done !== md) begin
            miscompares++;
            $display("FAIL tmo_abort: rd=%h err=%b done=%0d required deadbeef 1 %0d",
                     rd, timeout_err, mac_done, md);
        end
        wait_cfg = 0;
        ref_mem[8'h44] = 32'hA5A5_0001;
        xfer(1, 1, 8'h44, 32'hA5A5_0001, 1'b1, rd, lat, slen, sa, sd, sr, sw);
        model_last = 1;
        vectors++;
        if (lat !== 2 || timeout_err !== 1'b1 || rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL tmo_sticky: lat=%0d err=%b rd=%h required 2 1 deadbeef", lat, timeout_err, rd);
        end
    endtask

    task automatic test_reset_mid();
        int md;
        bit seen;
        wait_cfg = 1000;
        md = mac_done;
        @(negedge clock);
        c0_address = 8'h11; c0_read_req = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        vectors++;
        if (avm_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_access: rd=%b required 1", avm_read);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        c0_read_req = 1'b0;
        vectors++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0 || c0_busy !== 1'b1 || c1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_out: r=%b w=%b b0=%b b1=%b required 0 0 1 1",
                     avm_read, avm_write, c0_busy, c1_busy);
        end
        vectors++;
        if (timeout_err !== 1'b0 || c0_readdata !== 32'h0 || avm_address !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_state: err=%b rd=%h a=%h required 0 0 0",
                     timeout_err, c0_readdata, avm_address);
        end
        @(negedge clock);
        reset = 1'b0;
        model_last = 1;
        seen = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (!c0_busy || !c1_busy || avm_read || avm_write) seen = 1;
        end
        vectors++;
        if (seen || mac_done !== md) begin
            miscompares++;
            $display("FAIL rstmid_quiet: activity=%b done=%0d required 0 %0d", seen, mac_done, md);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2, sd;
        logic [7:0]  a, sa;
        logic        sr, sw;
        int          l1, l2, s1, s2, md, c;
        wait_cfg = 0;
        for (int it = 0; it < 3; it++) begin
            c = int'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 63)) | ((c == 1) ? 8'h40 : 8'h00);
            md = mac_done;
            xfer(c, 0, a, 32'h0, 1'b1, rd1, l1, s1, sa, sd, sr, sw);
            xfer(c, 0, a, 32'h0, 1'b0, rd2, l2, s2, sa, sd, sr, sw);
            model_last = c;
            vectors++;
            if (l1 !== 2 || l2 !== 3 || mac_done - md !== 2) begin
                miscompares++;
                $display("FAIL b2b it%0d: lat=%0d,%0d xfers=%0d required 2,3 2", it, l1, l2, mac_done - md);
            end
            vectors++;
            if (rd1 !== ref_mem[a] || rd2 !== ref_mem[a]) begin
                miscompares++;
                $display("FAIL b2b_data it%0d: %h %h required %h", it, rd1, rd2, ref_mem[a]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, sd;
        logic [7:0]  a, sa;
        logic        sr, sw;
        int          lat, slen, c, m, w;
        for (int it = 0; it < 24; it++) begin
            c = int'($urandom_range(0, 1));
            m = int'($urandom_range(0, 2));
            w = int'($urandom_range(0, 4));
            a = 8'($urandom_range(0, 63)) | ((c == 1) ? 8'h40 : 8'h00);
            d = $urandom;
            wait_cfg = w;
            if (m != 0) ref_mem[a] = d;
            xfer(c, m, a, d, 1'b1, rd, lat, slen, sa, sd, sr, sw);
            model_last = c;
            vectors++;
            if (lat !== 2 + w || slen !== 1 + w) begin
                miscompares++;
                $display("FAIL rand_timing it%0d: lat=%0d strobe=%0d required %0d %0d",
                         it, lat, slen, 2 + w, 1 + w);
            end
            vectors++;
            if (sa !== a || sw !== (m != 0) || sr !== (m == 0) || (m != 0 && sd !== d)) begin
                miscompares++;
                $display("FAIL rand_bus it%0d: a=%h r=%b w=%b d=%h required %h %b %b %h",
                         it, sa, sr, sw, sd, a, m == 0, m != 0, d);
            end
            if (m == 0) begin
                vectors++;
                if (rd !== ref_mem[a]) begin
                    miscompares++;
                    $display("FAIL rand_rdata it%0d: %h required %h", it, rd, ref_mem[a]);
                end
            end
        end
    endtask

    task automatic test_config_seq();
        logic [31:0] rda, rdb, d, sd;
        logic [7:0]  a, sa;
        logic        sr, sw;
        int          la, lb, sla, slb, n0, n1, md, bad;
        rand_wait = 1'b1;
        cfg_done = 1'b0;
        n0 = 0; n1 = 0; bad = 0;
        md = mac_done;
        fork
            begin
                for (int i = 0; i < 27; i++) begin
                    a = 8'h20 + 8'(i);
                    d = $urandom;
                    ref_mem[a] = d;
                    xfer(0, 1, a, d, 1'b1, rda, la, sla, sa, sd, sr, sw);
                    if (la > 0) n0++;
                end
                cfg_done = 1'b1;
            end
            begin
                int k;
                logic [7:0] pa;
                k = 0;
                while (!cfg_done) begin
                    pa = 8'h80 + 8'(k % 4);
                    xfer(1, 0, pa, 32'h0, 1'b0, rdb, lb, slb, sa, sd, sr, sw);
                    if (lb > 0) begin
                        n1++;
                        if (rdb !== ref_mem[pa]) bad++;
                    end
                    k++;
                end
            end
        join
        rand_wait = 1'b0;
        vectors++;
        if (n0 !== 27 || mac_done - md !== n0 + n1) begin
            miscompares++;
            $display("FAIL cfg_count: seq=%0d polls=%0d bus=%0d required 27 and %0d",
                     n0, n1, mac_done - md, n0 + n1);
        end
        vectors++;
        if (bad !== 0 || n1 < 2) begin
            miscompares++;
            $display("FAIL cfg_poll: bad=%0d polls=%0d required 0 and >=2", bad, n1);
        end
        for (int i = 0; i < 27; i++) begin
            vectors++;
            if (mac_mem[8'h20 + i] !== ref_mem[8'h20 + i]) begin
                miscompares++;
                $display("FAIL cfg_mem[%0d]: %h required %h", i, mac_mem[8'h20 + i], ref_mem[8'h20 + i]);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        c0_address = '0; c0_writedata = '0; c0_read_req = 1'b0; c0_write_req = 1'b0;
        c1_address = '0; c1_writedata = '0; c1_read_req = 1'b0; c1_write_req = 1'b0;
        avm_waitrequest = 1'b1; avm_readdata = '0;
        wait_cfg = 0; rand_wait = 1'b0; cur_wait = 0; active = 1'b0;
        wcnt = 0; scnt = 0; mac_done = 0; model_last = 1; cfg_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mac_mem[i] = $urandom;
            ref_mem[i] = mac_mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_config_seq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
